quick_attack_sequencer: RTL and testbench
=========================================

# quick_attack_sequencer

Control FSM for Meowth's quick-attack animation. It sequences the sprite path one frame at a time: draw the sprite, wait for a frame tick, erase the old image, step the x offset by one pixel, then redraw. It sits directly upstream of the sprite position and draw datapath. It drives the step enable of the x-offset register, the sprite drawer enable, the background-erase enable and the frame-tick generator enable. It consumes their completion pulses and tells the battle controller when the attack is finished.

## Interface
- STEPS, default 50: total one-pixel steps per attack (25 left, then 25 back). Legal range 0..63.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- start  in  1  request to run one attack; sampled only in IDLE.
- draw_done  in  1  one-cycle pulse from the sprite drawer after its last pixel write.
- erase_done  in  1  one-cycle pulse from the background-erase drawer after its last pixel write.
- frame_tick  in  1  one-cycle frame pulse from the frame counter.
- enable_animate  out  1  run enable for the frame counter.
- enable_draw  out  1  level enable for the sprite drawer.
- enable_erase  out  1  level enable for the erase drawer.
- step  out  1  one-cycle pulse; advances the x-offset register by one pixel.
- plot  out  1  VGA write enable; equals enable_draw OR enable_erase.
- colour_sel  out  1  0 selects sprite colour, 1 selects background colour; equals enable_erase.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the attack completes.
- step_count  out  6  number of steps issued in the current attack.

## Operation
- States: IDLE, DRAW, WAIT, ERASE, STEP, FINISH. Encoding is free.
- All outputs are registered Moore outputs decoded from the state register. No input feeds an output combinationally.
- IDLE: all outputs are 0. On start=1, clear step_count and go to DRAW.
- DRAW: enable_draw=1, enable_animate=1.
  - On draw_done with step_count==STEPS, go to FINISH.
  - On draw_done otherwise, go to WAIT.
- WAIT: enable_animate=1. On frame_tick, go to ERASE.
- ERASE: enable_erase=1, colour_sel=1, enable_animate=1. On erase_done, go to STEP.
- STEP: step=1, enable_animate=1.
  - Lasts exactly one cycle.
  - step_count increments by 1 on exit.
  - Always goes to DRAW.
- FINISH: done=1 for exactly one cycle, then go to IDLE. The final sprite image stays on screen.
- busy is high in DRAW, WAIT, ERASE, STEP and FINISH.
- Ignored inputs:
  - frame_tick outside WAIT is ignored and not remembered. A tick that coincides with draw_done is lost; the FSM waits for the next tick.
  - draw_done outside DRAW is ignored.
  - erase_done outside ERASE is ignored.
  - start outside IDLE is ignored, including during FINISH.
- step_count arithmetic: 6-bit unsigned. It never exceeds STEPS, so it never wraps.
- STEPS=0: start leads to DRAW, then draw_done leads straight to FINISH. No step, erase or wait occurs.
- Reset mid-operation:
  - All outputs drop to 0 asynchronously and step_count returns to 0.
  - After reset deasserts, the FSM stays in IDLE until a new start.
  - Downstream blocks receive enable low and must reset their own counters.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- start at cycle N (in IDLE) gives DRAW from cycle N+1: enable_draw, busy and enable_animate are high at N+1.
- draw_done at cycle M gives the next state at M+1; enable_draw is low at M+1.
- frame_tick at cycle T (in WAIT) gives enable_erase and colour_sel high at T+1.
- erase_done at cycle E gives:
  - step=1 at E+1 only;
  - enable_draw high and step_count incremented at E+2.
- Final draw_done at cycle F gives done=1 at F+1; busy is low and the state is IDLE at F+2.
- Per-step latency: (cycles to next frame_tick) + erase length + 1 + draw length.
- Exactly STEPS step pulses and STEPS+1 draw passes occur per attack.

## Test plan
- Reset then idle: assert reset for 3 cycles with start=0 -> all outputs 0 and step_count=0 throughout.
- Full attack, STEPS=50: drawer and eraser models pulse done 10 cycles after their enable rises; frame_tick every 100 cycles -> exactly 50 step pulses, 51 draw passes, done once, final step_count=50, and plot never high while both enables are low.
- Lost tick: assert frame_tick in the same cycle as draw_done -> FSM stays in WAIT until the next tick; no erase in between.
- STEPS=0: start -> one draw pass, done=1 the cycle after draw_done, step never asserted.
- Start while busy: pulse start in WAIT and in FINISH -> no restart and no step_count clear; a start in IDLE afterwards begins a new attack with step_count=0.
- Reset mid-ERASE at step_count=17 -> enable_erase, plot and busy drop immediately, step_count=0; after release a new start runs a full 50-step attack.

Source files
------------

// File: rtl/quick_attack_sequencer.sv
// Frame-by-frame sequencer for the quick-attack sprite path: draw, wait for a
// frame tick, erase, step one pixel, redraw, until STEPS steps have been taken.
module quick_attack_sequencer #(
    parameter int STEPS = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       draw_done,
    input  logic       erase_done,
    input  logic       frame_tick,
    output logic       enable_animate,
    output logic       enable_draw,
    output logic       enable_erase,
    output logic       step,
    output logic       plot,
    output logic       colour_sel,
    output logic       busy,
    output logic       done,
    output logic [5:0] step_count
);

    localparam logic [5:0] LAST_STEP = 6'(STEPS);

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        WAIT,
        ERASE,
        STEP,
        FINISH
    } state_t;

    state_t state, state_next;
    logic   animate_d, draw_d, erase_d, step_d, busy_d, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRAW;
            DRAW:    if (draw_done) state_next = (step_count == LAST_STEP) ? FINISH : WAIT;
            WAIT:    if (frame_tick) state_next = ERASE;
            ERASE:   if (erase_done) state_next = STEP;
            STEP:    state_next = DRAW;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each flop
    // already holds the Moore value of the state being entered.
    always_comb begin
        draw_d    = (state_next == DRAW);
        erase_d   = (state_next == ERASE);
        step_d    = (state_next == STEP);
        done_d    = (state_next == FINISH);
        busy_d    = (state_next != IDLE);
        animate_d = busy_d && !done_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable_animate <= 1'b0;
            enable_draw    <= 1'b0;
            enable_erase   <= 1'b0;
            step           <= 1'b0;
            plot           <= 1'b0;
            colour_sel     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            enable_animate <= animate_d;
            enable_draw    <= draw_d;
            enable_erase   <= erase_d;
            step           <= step_d;
            plot           <= draw_d | erase_d;
            colour_sel     <= erase_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                      step_count <= 6'd0;
        else if (state == IDLE && start) step_count <= 6'd0;
        else if (state == STEP)         step_count <= step_count + 6'd1;
    end

endmodule

// File: tb/tb_quick_attack_sequencer.sv
// Directed bench: single-cycle vector table plus multi-cycle attack sequences
// with drawer/eraser/frame-tick models.
module tb_quick_attack_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // main DUT (STEPS=50): inputs come from hand drivers or the models
    logic auto_mode = 1'b0;
    logic h_start = 1'b0, h_dd = 1'b0, h_ed = 1'b0, h_ft = 1'b0;
    logic m_dd, m_ed, m_ft;
    logic draw_done, erase_done, frame_tick;
    logic enable_animate, enable_draw, enable_erase, step, plot, colour_sel, busy, done;
    logic [5:0] step_count;

    assign draw_done  = auto_mode ? m_dd : h_dd;
    assign erase_done = auto_mode ? m_ed : h_ed;
    assign frame_tick = auto_mode ? m_ft : h_ft;

    quick_attack_sequencer #(.STEPS(50)) dut (
        .clock(clock), .reset(reset), .start(h_start),
        .draw_done(draw_done), .erase_done(erase_done), .frame_tick(frame_tick),
        .enable_animate(enable_animate), .enable_draw(enable_draw),
        .enable_erase(enable_erase), .step(step), .plot(plot),
        .colour_sel(colour_sel), .busy(busy), .done(done), .step_count(step_count)
    );

    // STEPS=0 instance
    logic start0 = 1'b0, dd0 = 1'b0, zero = 1'b0;
    logic anim0, draw0, erase0, step0, plot0, col0, busy0, done0;
    logic [5:0] cnt0;

    quick_attack_sequencer #(.STEPS(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0),
        .draw_done(dd0), .erase_done(zero), .frame_tick(zero),
        .enable_animate(anim0), .enable_draw(draw0),
        .enable_erase(erase0), .step(step0), .plot(plot0),
        .colour_sel(col0), .busy(busy0), .done(done0), .step_count(cnt0)
    );

    // drawer/eraser pulse done 10 cycles after enable rises; tick every 100
    int dcnt = 0, ecnt = 0, fcnt = 0;
    assign m_dd = enable_draw  && (dcnt == 10);
    assign m_ed = enable_erase && (ecnt == 10);
    assign m_ft = (fcnt == 99);
    always @(posedge clock) begin
        dcnt <= enable_draw  ? dcnt + 1 : 0;
        ecnt <= enable_erase ? ecnt + 1 : 0;
        fcnt <= (fcnt == 99) ? 0 : fcnt + 1;
    end

    // monitors, sampled on the falling edge
    int steps_seen = 0, draws_seen = 0, dones_seen = 0, plot_bad = 0, steps0_seen = 0;
    logic draw_prev = 1'b0;
    always @(negedge clock) begin
        if (step) steps_seen <= steps_seen + 1;
        if (done) dones_seen <= dones_seen + 1;
        if (enable_draw && !draw_prev) draws_seen <= draws_seen + 1;
        draw_prev <= enable_draw;
        if (plot !== (enable_draw | enable_erase) || colour_sel !== enable_erase)
            plot_bad <= plot_bad + 1;
        if (step0) steps0_seen <= steps0_seen + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({enable_draw, enable_erase, enable_animate, step, busy, done});
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, "_outs"}, outs(), 0);
        chk({name, "_plotcol"}, int'({plot, colour_sel}), 0);
        chk({name, "_cnt"}, int'(step_count), 0);
    endtask

    typedef struct {
        logic       st, dd, ed, ft;
        logic [5:0] exp;   // {draw, erase, animate, step, busy, done}
        logic [5:0] cnt;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic st, dd, ed, ft, input logic [5:0] exp, input logic [5:0] cnt);
        vec_t v;
        v.st = st; v.dd = dd; v.ed = ed; v.ft = ft; v.exp = exp; v.cnt = cnt;
        vt.push_back(v);
    endtask

    task automatic run_attack(input string nm);
        int s0, d0, n0;
        bit got;
        s0 = steps_seen; d0 = draws_seen; n0 = dones_seen;
        @(negedge clock) h_start = 1'b1;
        @(posedge clock); #1;
        chk({nm, "_start_draw"}, int'({enable_draw, busy, enable_animate}), 7);
        chk({nm, "_start_cnt"}, int'(step_count), 0);
        @(negedge clock) h_start = 1'b0;
        got = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(posedge clock); #1;
            if (done) got = 1;
        end
        chk({nm, "_done_seen"}, int'(got), 1);
        chk({nm, "_final_cnt"}, int'(step_count), 50);
        chk({nm, "_finish_busy"}, int'(busy), 1);
        h_start = 1'b1;   // start during FINISH must be ignored
        @(posedge clock); #1;
        h_start = 1'b0;
        chk({nm, "_idle_after"}, int'({busy, done, enable_draw}), 0);
        chk({nm, "_cnt_kept"}, int'(step_count), 50);
        repeat (3) @(posedge clock);
        #1;
        chk({nm, "_still_idle"}, int'(busy), 0);
        chk({nm, "_steps"}, steps_seen - s0, 50);
        chk({nm, "_draws"}, draws_seen - d0, 51);
        chk({nm, "_dones"}, dones_seen - n0, 1);
    endtask

    initial begin
        // table: inputs in one cycle, outputs expected after that edge
        add(0,0,0,0, 6'b000000, 0);
        add(0,1,1,1, 6'b000000, 0);  // stray pulses in IDLE
        add(1,0,0,0, 6'b101010, 0);  // start -> DRAW
        add(0,0,0,1, 6'b101010, 0);  // tick in DRAW ignored
        add(0,0,1,0, 6'b101010, 0);  // erase_done in DRAW ignored
        add(0,1,0,1, 6'b001010, 0);  // draw_done with coincident tick -> WAIT, tick lost
        add(0,0,0,0, 6'b001010, 0);
        add(0,0,1,0, 6'b001010, 0);  // erase_done in WAIT ignored
        add(0,1,0,0, 6'b001010, 0);  // draw_done in WAIT ignored
        add(0,0,0,1, 6'b011010, 0);  // tick -> ERASE
        add(0,1,0,0, 6'b011010, 0);
        add(0,0,1,0, 6'b001110, 0);  // erase_done -> STEP
        add(0,0,0,0, 6'b101010, 1);  // DRAW, count incremented
        add(0,1,0,0, 6'b001010, 1);
        add(1,0,0,0, 6'b001010, 1);  // start in WAIT: no restart, no clear
        add(0,0,0,1, 6'b011010, 1);
        add(0,0,1,1, 6'b001110, 1);
        add(1,0,0,0, 6'b101010, 2);  // start in STEP ignored

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk_all_zero($sformatf("reset_c%0d", i));
        end
        @(negedge clock) reset = 1'b0;

        foreach (vt[i]) begin
            @(negedge clock);
            h_start = vt[i].st; h_dd = vt[i].dd; h_ed = vt[i].ed; h_ft = vt[i].ft;
            @(posedge clock); #1;
            chk($sformatf("vec%0d_outs", i), outs(), int'(vt[i].exp));
            chk($sformatf("vec%0d_plotcol", i), int'({plot, colour_sel}),
                int'({vt[i].exp[5] | vt[i].exp[4], vt[i].exp[4]}));
            chk($sformatf("vec%0d_cnt", i), int'(step_count), int'(vt[i].cnt));
        end
        @(negedge clock);
        h_start = 0; h_dd = 0; h_ed = 0; h_ft = 0;
        reset = 1'b1;
        #1 chk_all_zero("reset_mid_draw");
        @(negedge clock) reset = 1'b0;

        // full attack with models
        auto_mode = 1'b1;
        run_attack("attack1");

        // reset mid-ERASE at step_count 17
        begin
            bit got;
            @(negedge clock) h_start = 1'b1;
            @(posedge clock); #1;
            chk("midrst_start_clears_cnt", int'(step_count), 0);
            @(negedge clock) h_start = 1'b0;
            got = 0;
            for (int i = 0; i < 10000 && !got; i++) begin
                @(posedge clock); #1;
                if (enable_erase && step_count == 6'd17) got = 1;
            end
            chk("midrst_reached_erase17", int'(got), 1);
            #2 reset = 1'b1;
            #1;
            chk("midrst_async_outs", int'({enable_erase, plot, busy, enable_animate}), 0);
            chk("midrst_async_cnt", int'(step_count), 0);
            @(negedge clock) reset = 1'b0;
            repeat (5) @(posedge clock);
            #1 chk("midrst_stays_idle", int'(busy), 0);
        end
        run_attack("attack2");
        chk("plot_consistency", plot_bad, 0);

        // STEPS=0 instance
        @(negedge clock) start0 = 1'b1;
        @(posedge clock); #1;
        chk("s0_draw", int'({draw0, busy0, anim0}), 7);
        @(negedge clock) start0 = 1'b0;
        repeat (2) @(negedge clock);
        dd0 = 1'b1;
        @(posedge clock); #1;
        chk("s0_done", int'({done0, draw0, step0, busy0}), 9);
        @(negedge clock) dd0 = 1'b0;
        @(posedge clock); #1;
        chk("s0_idle", int'({busy0, done0}), 0);
        chk("s0_no_steps", steps0_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
